// File: rtl/aes_key_schedule_nk.sv
// On-demand AES key expansion for Nk = 4/6/8: keeps a sliding window of the last NK
// words and assembles one 128-bit round key per request, sharing a byte-serial S-box.
module aes_key_schedule_nk #(
    parameter int NK            = 4,
    parameter int EXTERNAL_SBOX = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NK*32-1:0] key_i,
    input  logic             start_i,
    input  logic             key_req_i,
    output logic [127:0]     key_o,
    output logic [127:0]     key_big_end_o,
    output logic             valid_o,
    output logic [3:0]       round_o,
    output logic             last_o,
    output logic [7:0]       sbox_sub_o,
    input  logic [7:0]       sbox_sub_i
);
    localparam int NR = NK + 6;
    localparam int IW = $clog2(NK);
    localparam logic [2:0] MOD_LAST = 3'(NK - 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_key_schedule_nk: NK must be 4, 6 or 8");
    end

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_GEN, S_COPY, S_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic needs_sub(input logic [2:0] m);
        return (m == 3'd0) || ((NK == 8) && (m == 3'd4));
    endfunction

    // Next step for word jj given generation index ii (mm = ii % NK).
    function automatic state_t pick(input logic [5:0] jj, input logic [5:0] ii,
                                    input logic [2:0] mm);
        if (jj < ii)        return S_COPY;
        else if (needs_sub(mm)) return S_SUB;
        else                return S_GEN;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  sub_cnt_q, sub_cnt_d;
    logic [31:0] win_q [NK];
    logic [31:0] win_d [NK];
    logic [31:0] key_q [4];
    logic [31:0] key_d [4];
    logic [31:0] sub_word_q, sub_word_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [5:0]  i_q, i_d;
    logic [5:0]  j_q, j_d;
    logic [2:0]  i_mod_q, i_mod_d;
    logic        valid_q, valid_d;
    logic [3:0]  round_q, round_d;
    logic        last_q, last_d;

    logic [31:0]   sub_src;
    logic [7:0]    sub_byte;
    logic [7:0]    sub_res;
    logic [31:0]   t_word;
    logic [31:0]   w_new;
    logic [IW-1:0] copy_idx;

    always_comb begin
        sub_src = (i_mod_q == 3'd0) ? {win_q[NK-1][23:0], win_q[NK-1][31:24]} : win_q[NK-1];
        unique case (sub_cnt_q)
            2'd0:    sub_byte = sub_src[31:24];
            2'd1:    sub_byte = sub_src[23:16];
            2'd2:    sub_byte = sub_src[15:8];
            default: sub_byte = sub_src[7:0];
        endcase
        sbox_sub_o = (state_q == S_SUB) ? sub_byte : 8'h00;
        sub_res    = (EXTERNAL_SBOX != 0) ? sbox_sub_i : sbox_fn(sub_byte);
    end

    always_comb begin
        t_word   = needs_sub(i_mod_q)
                   ? (sub_word_q ^ ((i_mod_q == 3'd0) ? {rcon_q, 24'h000000} : 32'h0))
                   : win_q[NK-1];
        w_new    = win_q[0] ^ t_word;
        copy_idx = IW'(j_q - i_q + 6'(NK));
    end

    always_comb begin
        state_d    = state_q;
        sub_cnt_d  = sub_cnt_q;
        win_d      = win_q;
        key_d      = key_q;
        sub_word_d = sub_word_q;
        rcon_d     = rcon_q;
        i_d        = i_q;
        j_d        = j_q;
        i_mod_d    = i_mod_q;
        valid_d    = valid_q;
        round_d    = round_q;

        unique case (state_q)
            S_IDLE: begin
                if (key_req_i && valid_q && !last_q) begin
                    valid_d = 1'b0;
                    state_d = pick(j_q, i_q, i_mod_q);
                end
            end
            S_SUB: begin
                unique case (sub_cnt_q)
                    2'd0:    sub_word_d[31:24] = sub_res;
                    2'd1:    sub_word_d[23:16] = sub_res;
                    2'd2:    sub_word_d[15:8]  = sub_res;
                    default: sub_word_d[7:0]   = sub_res;
                endcase
                sub_cnt_d = sub_cnt_q + 2'd1;
                if (sub_cnt_q == 2'd3) state_d = S_GEN;
            end
            S_GEN: begin
                for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
                win_d[NK-1]      = w_new;
                key_d[j_q[1:0]]  = w_new;
                if (i_mod_q == 3'd0) rcon_d = xtime(rcon_q);
                i_d     = i_q + 6'd1;
                j_d     = j_q + 6'd1;
                i_mod_d = (i_mod_q == MOD_LAST) ? 3'd0 : i_mod_q + 3'd1;
                state_d = (j_d[1:0] == 2'd0) ? S_DONE : pick(j_d, i_d, i_mod_d);
            end
            S_COPY: begin
                key_d[j_q[1:0]] = win_q[copy_idx];
                j_d     = j_q + 6'd1;
                state_d = (j_d[1:0] == 2'd0) ? S_DONE : pick(j_d, i_q, i_mod_q);
            end
            S_DONE: begin
                valid_d = 1'b1;
                round_d = round_q + 4'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new key overrides whatever was in flight, including a pending request.
        if (start_i) begin
            for (int k = 0; k < NK; k++) win_d[k] = key_i[NK*32-1-32*k -: 32];
            for (int k = 0; k < 4; k++)  key_d[k] = key_i[NK*32-1-32*k -: 32];
            state_d   = S_IDLE;
            sub_cnt_d = 2'd0;
            rcon_d    = 8'h01;
            i_d       = 6'(NK);
            j_d       = 6'd4;
            i_mod_d   = 3'd0;
            valid_d   = 1'b1;
            round_d   = 4'd0;
        end

        last_d = valid_d && (round_d == 4'(NR));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            sub_cnt_q  <= 2'd0;
            for (int k = 0; k < NK; k++) win_q[k] <= 32'h0;
            for (int k = 0; k < 4; k++)  key_q[k] <= 32'h0;
            sub_word_q <= 32'h0;
            rcon_q     <= 8'h01;
            i_q        <= 6'd0;
            j_q        <= 6'd0;
            i_mod_q    <= 3'd0;
            valid_q    <= 1'b0;
            round_q    <= 4'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_cnt_q  <= sub_cnt_d;
            win_q      <= win_d;
            key_q      <= key_d;
            sub_word_q <= sub_word_d;
            rcon_q     <= rcon_d;
            i_q        <= i_d;
            j_q        <= j_d;
            i_mod_q    <= i_mod_d;
            valid_q    <= valid_d;
            round_q    <= round_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        key_big_end_o = {key_q[0], key_q[1], key_q[2], key_q[3]};
        for (int b = 0; b < 16; b++) key_o[8*b +: 8] = key_big_end_o[127-8*b -: 8];
    end

    assign valid_o = valid_q;
    assign round_o = round_q;
    assign last_o  = last_q;

endmodule
